// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the register-file write port
// Burst lock keeps multi-beat writes atomic; the write port is driven from registers.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          WE,
  output logic [ADDR_WIDTH-1:0]         A3,
  output logic [DATA_WIDTH-1:0]         WD3,
  output logic [IDW-1:0]                grant_id,
  output logic                          locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        owner_q, owner_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] a3_q, a3_d;
  logic [DATA_WIDTH-1:0] wd3_q, wd3_d;

  logic                  found;
  int                    g;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  function automatic int modn(input int v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  // Grant selection looks only at valid, stall, state and pointer, never at addr/data.
  always_comb begin
    found = 1'b0;
    g     = 0;
    if (!rst && !stall) begin
      if (state_q == IDLE) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i == modn(int'(rr_ptr_q) + k))) begin
              found = 1'b1;
              g     = i;
            end
          end
        end
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && (i == int'(owner_q))) begin
            found = 1'b1;
            g     = i;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (g == i)) begin
        req_ready[i] = 1'b1;
        sel_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last     = req_last[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    we_d     = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    if (found) begin
      grant_d = IDW'(g);
      if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = IDW'(modn(g + 1));
      end else begin
        state_d = LOCKED;
        owner_d = IDW'(g);
      end
      // Writes to register 0 are swallowed: the port stays quiet and A3/WD3 hold.
      if (sel_addr != '0) begin
        we_d  = 1'b1;
        a3_d  = sel_addr;
        wd3_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      we_q     <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign WE       = we_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign grant_id = grant_q;
  assign locked   = (state_q == LOCKED);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed vector bench for rf_write_arbiter
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  req_valid;
  logic [2:0]  req_last;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [1:0]  grant_id;
  logic        locked;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .WE(WE), .A3(A3), .WD3(WD3), .grant_id(grant_id), .locked(locked)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [2:0]  valid;
    logic [2:0]  last;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [1:0]  gid;
    logic        lock;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic [2:0] v,
                              input logic [2:0] l, input logic [14:0] a,
                              input logic [95:0] d, input logic [2:0] rdy,
                              input logic we, input logic [4:0] a3,
                              input logic [31:0] wd3, input logic [1:0] gid,
                              input logic lock);
    vec_t t;
    t.rst = r; t.stall = s; t.valid = v; t.last = l; t.addr = a; t.data = d;
    t.rdy = rdy; t.we = we; t.a3 = a3; t.wd3 = wd3; t.gid = gid; t.lock = lock;
    return t;
  endfunction

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive, check ready mid-cycle, check registered outputs after the edge.
  task automatic run_vec(input int n, input vec_t v);
    rst = v.rst; stall = v.stall; req_valid = v.valid; req_last = v.last;
    req_addr = v.addr; req_data = v.data;
    #1;
    check($sformatf("v%0d ready", n), 96'(req_ready), 96'(v.rdy));
    @(posedge clk);
    #1;
    check($sformatf("v%0d WE", n), 96'(WE), 96'(v.we));
    check($sformatf("v%0d A3", n), 96'(A3), 96'(v.a3));
    check($sformatf("v%0d WD3", n), 96'(WD3), 96'(v.wd3));
    check($sformatf("v%0d grant_id", n), 96'(grant_id), 96'(v.gid));
    check($sformatf("v%0d locked", n), 96'(locked), 96'(v.lock));
    @(negedge clk);
  endtask

  localparam logic [14:0] A_ALL = {5'd3, 5'd2, 5'd1};
  localparam logic [95:0] D_ALL = {32'h300, 32'h200, 32'h100};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; req_valid = '0; req_last = '1; req_addr = '0; req_data = '0;

    vecs.push_back(mk(1, 0, 3'b111, 3'b111, A_ALL, D_ALL, 3'b000, 0, 0, 0, 0, 0));
    // single write from requester 1
    vecs.push_back(mk(0, 0, 3'b010, 3'b111, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b010, 1, 5, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(0, 0, 3'b000, 3'b111, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b000, 0, 5, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(1, 0, 3'b000, 3'b111, A_ALL, D_ALL, 3'b000, 0, 0, 0, 0, 0));
    // rotation 0,1,2,0,1,2 with pointer wrap
    vecs.push_back(mk(0, 0, 3'b111, 3'b111, A_ALL, D_ALL, 3'b001, 1, 1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b111, A_ALL, D_ALL, 3'b010, 1, 2, 32'h200, 1, 0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b111, A_ALL, D_ALL, 3'b100, 1, 3, 32'h300, 2, 0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b111, A_ALL, D_ALL, 3'b001, 1, 1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b111, A_ALL, D_ALL, 3'b010, 1, 2, 32'h200, 1, 0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b111, A_ALL, D_ALL, 3'b100, 1, 3, 32'h300, 2, 0));
    // move pointer to 2, then burst from requester 2 while requester 0 waits
    vecs.push_back(mk(0, 0, 3'b010, 3'b111, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h77, 32'h0}, 3'b010, 1, 7, 32'h77, 1, 0));
    vecs.push_back(mk(0, 0, 3'b101, 3'b011, {5'd8, 5'd0, 5'd4}, {32'h808, 32'h0, 32'h44}, 3'b100, 1, 8, 32'h808, 2, 1));
    vecs.push_back(mk(0, 0, 3'b001, 3'b011, {5'd8, 5'd0, 5'd4}, {32'h808, 32'h0, 32'h44}, 3'b000, 0, 8, 32'h808, 2, 1));
    vecs.push_back(mk(0, 0, 3'b101, 3'b011, {5'd9, 5'd0, 5'd4}, {32'h909, 32'h0, 32'h44}, 3'b100, 1, 9, 32'h909, 2, 1));
    vecs.push_back(mk(0, 0, 3'b101, 3'b111, {5'd10, 5'd0, 5'd4}, {32'hA0A, 32'h0, 32'h44}, 3'b100, 1, 10, 32'hA0A, 2, 0));
    vecs.push_back(mk(0, 0, 3'b001, 3'b111, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h44}, 3'b001, 1, 4, 32'h44, 0, 0));
    // write to register 0 is dropped
    vecs.push_back(mk(0, 0, 3'b001, 3'b111, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 3'b001, 0, 4, 32'h44, 0, 0));
    // stall for three cycles, pointer is 1
    vecs.push_back(mk(0, 1, 3'b011, 3'b111, A_ALL, D_ALL, 3'b000, 0, 4, 32'h44, 0, 0));
    vecs.push_back(mk(0, 1, 3'b011, 3'b111, A_ALL, D_ALL, 3'b000, 0, 4, 32'h44, 0, 0));
    vecs.push_back(mk(0, 1, 3'b011, 3'b111, A_ALL, D_ALL, 3'b000, 0, 4, 32'h44, 0, 0));
    vecs.push_back(mk(0, 0, 3'b011, 3'b111, A_ALL, D_ALL, 3'b010, 1, 2, 32'h200, 1, 0));
    vecs.push_back(mk(0, 0, 3'b011, 3'b111, A_ALL, D_ALL, 3'b001, 1, 1, 32'h100, 0, 0));
    // reset mid-burst
    vecs.push_back(mk(0, 0, 3'b010, 3'b101, {5'd0, 5'd12, 5'd0}, {32'h0, 32'hC0C, 32'h0}, 3'b010, 1, 12, 32'hC0C, 1, 1));
    vecs.push_back(mk(1, 0, 3'b111, 3'b111, A_ALL, D_ALL, 3'b000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b111, A_ALL, D_ALL, 3'b001, 1, 1, 32'h100, 0, 0));

    @(negedge clk);
    for (int n = 0; n < vecs.size(); n++) run_vec(n, vecs[n]);

    // Stall inside a burst: lock must survive, then requester 0 follows once the burst ends.
    rst = 1'b0; stall = 1'b0; req_valid = 3'b011; req_last = 3'b101;
    req_addr = {5'd0, 5'd20, 5'd6}; req_data = {32'h0, 32'h2020, 32'h66};
    #1;
    check("burst_stall grant1", 96'(req_ready), 96'(3'b010));
    @(posedge clk); #1;
    check("burst_stall locked", 96'(locked), 96'(1'b1));
    check("burst_stall A3 20", 96'(A3), 96'(5'd20));
    @(negedge clk);
    stall = 1'b1;
    #1;
    check("burst_stall ready0", 96'(req_ready), 96'(3'b000));
    @(posedge clk); #1;
    check("burst_stall WE0", 96'(WE), 96'(1'b0));
    check("burst_stall still locked", 96'(locked), 96'(1'b1));
    @(negedge clk);
    stall = 1'b0; req_last = 3'b111; req_addr = {5'd0, 5'd21, 5'd6}; req_data = {32'h0, 32'h2121, 32'h66};
    #1;
    check("burst_stall owner only", 96'(req_ready), 96'(3'b010));
    @(posedge clk); #1;
    check("burst_stall A3 21", 96'(A3), 96'(5'd21));
    check("burst_stall unlocked", 96'(locked), 96'(1'b0));
    @(negedge clk);
    #1;
    check("burst_stall next grant0", 96'(req_ready), 96'(3'b001));
    @(posedge clk); #1;
    check("burst_stall WD3 66", 96'(WD3), 96'(32'h66));
    check("burst_stall gid0", 96'(grant_id), 96'(2'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
